full_mat_sched: RTL and testbench

- Two-requester scheduler and sequencer for the shared 6x6 matrix-multiply datapath (full_mat).
- Grants the datapath to one requester at a time using round-robin arbitration.
- For each job: clears the datapath counter, drives its enable for the exact job length, then pulses result-capture and a per-requester done.
- The top level uses the one-hot grant to select which requester's dataa/datab feed the datapath; this block does not carry operand data.

---
 rtl/full_mat_sched.sv | 161 ++++++++++++++++
 tb/tb_full_mat_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/full_mat_sched.sv
// -----------------------------------------------------------------------------
// full_mat_sched
//
// Purpose:
//   Schedules and sequences jobs for the shared 6x6 matrix-multiply datapath
//   (full_mat) on behalf of two requesters.
//   - Round-robin arbitration grants the datapath to one requester at a time.
//   - Each job runs through the same sequence:
//       CLEAR : the datapath counter is reset.
//       RUN   : the datapath is enabled for the job length.
//       DONE  : the result is captured and the granted requester gets a done
//               pulse.
//   - Operand steering is done at the top level using the one-hot grant.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   req[1:0]     in   per-requester job request (level, held until done)
//   req_mode[1:0]in   per-requester mode, 1 = matrix, 0 = parallel; sampled at grant
//   gnt[1:0]     out  one-hot grant, held from grant through the DONE cycle
//   done[1:0]    out  one-cycle job-complete pulse to the granted requester
//   busy         out  high whenever the sequencer is not idle
//   fm_rst       out  datapath reset (during reset and CLEAR)
//   fm_en        out  datapath enable (RUN only)
//   fm_mat_mode  out  latched job mode, valid CLEAR through DONE
//   res_capture  out  one-cycle pulse in DONE; datapath result valid then
// -----------------------------------------------------------------------------
module full_mat_sched #(
    parameter int N        = 6,
    parameter int MULT_LAT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] req_mode,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       busy,
    output logic       fm_rst,
    output logic       fm_en,
    output logic       fm_mat_mode,
    output logic       res_capture
);

    localparam int MAT_LEN = N + MULT_LAT + 2;
    localparam int PAR_LEN = MULT_LAT + 2;
    localparam int CNT_W   = $clog2(MAT_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         gnt_q, gnt_d;
    logic               mode_q, mode_d;
    // Index of the requester served last; the other one wins a tie.
    logic               last_q, last_d;
    logic [1:0]         done_q, done_d;
    logic               busy_q, busy_d;
    logic               fm_rst_q, fm_rst_d;
    logic               fm_en_q, fm_en_d;
    logic               res_capture_q, res_capture_d;

    logic               winner;
    logic [CNT_W-1:0]   len_m1;

    // Terminal count of RUN for the latched job mode.
    assign len_m1 = mode_q ? CNT_W'(MAT_LEN - 1) : CNT_W'(PAR_LEN - 1);

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned; a missing default would infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        gnt_d         = gnt_q;
        mode_d        = mode_q;
        last_d        = last_q;
        // A single requester always wins; with both pending, the one not
        // served last wins.
        winner        = (req == 2'b11) ? ~last_q : req[1];

        unique case (state_q)
            S_IDLE: begin
                gnt_d  = 2'b00;
                mode_d = 1'b0;
                if (req != 2'b00) begin
                    gnt_d   = winner ? 2'b10 : 2'b01;
                    mode_d  = req_mode[winner];
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_q == len_m1) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                last_d  = gnt_q[1];
                gnt_d   = 2'b00;
                mode_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered: decode them from the next state so they
        // line up with the state they describe.
        busy_d        = (state_d != S_IDLE);
        fm_rst_d      = (state_d == S_CLEAR);
        fm_en_d       = (state_d == S_RUN);
        res_capture_d = (state_d == S_DONE);
        done_d        = (state_d == S_DONE) ? gnt_d : 2'b00;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            gnt_q         <= 2'b00;
            mode_q        <= 1'b0;
            last_q        <= 1'b1;
            done_q        <= 2'b00;
            busy_q        <= 1'b0;
            fm_rst_q      <= 1'b1;
            fm_en_q       <= 1'b0;
            res_capture_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            gnt_q         <= gnt_d;
            mode_q        <= mode_d;
            last_q        <= last_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            fm_rst_q      <= fm_rst_d;
            fm_en_q       <= fm_en_d;
            res_capture_q <= res_capture_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign fm_rst      = fm_rst_q;
    assign fm_en       = fm_en_q;
    assign fm_mat_mode = mode_q;
    assign res_capture = res_capture_q;

endmodule

// File: tb/tb_full_mat_sched.sv
// -----------------------------------------------------------------------------
// tb_full_mat_sched
//
// Purpose:
//   Self-checking bench for full_mat_sched.
//   - Reference model: a job timeline. Each job has a phase:
//       phase 0          CLEAR
//       phase 1 .. LEN   RUN
//       phase LEN+1      DONE
//     and -1 means idle.
//   - Every cycle the expected outputs are derived from that phase and
//     compared with the DUT outputs.
//   - Scenario tasks add their own checks on top:
//       - job latency
//       - enable length
//       - grant order
//       - mode stability
//       - reset behaviour
// -----------------------------------------------------------------------------
module tb_full_mat_sched;

    localparam int N        = 6;
    localparam int MULT_LAT = 4;
    localparam int MAT_LEN  = N + MULT_LAT + 2;
    localparam int PAR_LEN  = MULT_LAT + 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] req_mode;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic       fm_rst;
    logic       fm_en;
    logic       fm_mat_mode;
    logic       res_capture;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int m_phase = -1;
    int m_owner = 0;
    int m_last  = 1;
    bit m_mode  = 1'b0;

    full_mat_sched #(.N(N), .MULT_LAT(MULT_LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_mode    (req_mode),
        .gnt         (gnt),
        .done        (done),
        .busy        (busy),
        .fm_rst      (fm_rst),
        .fm_en       (fm_en),
        .fm_mat_mode (fm_mat_mode),
        .res_capture (res_capture)
    );

    always #5 clk = ~clk;

    function automatic int job_len(input bit mode);
        return mode ? MAT_LEN : PAR_LEN;
    endfunction

    // Advance the reference model across one clock edge.
    task automatic model_edge();
        if (!rst_n) begin
            m_phase = -1;
            m_last  = 1;
        end else if (m_phase < 0) begin
            if (req != 2'b00) begin
                if (req == 2'b11)  m_owner = 1 - m_last;
                else               m_owner = req[1] ? 1 : 0;
                m_mode  = req_mode[m_owner];
                m_phase = 0;
            end
        end else if (m_phase == job_len(m_mode) + 1) begin
            m_last  = m_owner;
            m_phase = -1;
        end else begin
            m_phase++;
        end
    endtask

    // One clock: inputs are already driven, outputs are sampled 1 time unit
    // after the edge and compared against the model, then return at negedge.
    task automatic step();
        logic [8:0] exp_v, act_v;
        logic [1:0] g;
        int         len;
        @(posedge clk);
        model_edge();
        #1;
        len = job_len(m_mode);
        g   = (m_phase >= 0) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
        exp_v = {g,
                 (m_phase == len + 1) ? g : 2'b00,
                 m_phase >= 0,
                 (m_phase == 0) || !rst_n,
                 (m_phase >= 1) && (m_phase <= len),
                 (m_phase >= 0) ? m_mode : 1'b0,
                 m_phase == len + 1};
        act_v = {gnt, done, busy, fm_rst, fm_en, fm_mat_mode, res_capture};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL outputs t=%0t got gnt,done,busy,rst,en,mode,cap=%b expected %b",
                     $time, act_v, exp_v);
        end
        checks++;
        if ($countones(gnt) > 1 || (done & ~gnt) != 2'b00 || (fm_en && fm_rst)) begin
            failures++;
            $display("FAIL invariants t=%0t got gnt=%b done=%b en=%b rst=%b expected exclusive",
                     $time, gnt, done, fm_en, fm_rst);
        end
        @(negedge clk);
    endtask

    // Steps until a done pulse (bounded).
    // - drop_at   : release req after that many enable cycles.
    // - toggle_at : flip req_mode after that many enable cycles.
    // Returns edge count, enable count, the done value seen and whether
    // fm_mat_mode stayed constant while busy.
    task automatic wait_done(input int drop_at, input int toggle_at,
                             output int steps, output int en_cnt,
                             output logic [1:0] d, output bit mode_stable);
        logic first_mode;
        bit   have_mode;
        steps       = 0;
        en_cnt      = 0;
        d           = 2'b00;
        mode_stable = 1'b1;
        have_mode   = 1'b0;
        first_mode  = 1'b0;
        while (steps < 40 && d == 2'b00) begin
            step();
            steps++;
            if (busy) begin
                if (!have_mode) begin
                    first_mode = fm_mat_mode;
                    have_mode  = 1'b1;
                end else if (fm_mat_mode !== first_mode) begin
                    mode_stable = 1'b0;
                end
            end
            if (fm_en) begin
                en_cnt++;
                if (en_cnt == drop_at)   req      = 2'b00;
                if (en_cnt == toggle_at) req_mode = ~req_mode;
            end
            if (done != 2'b00) d = done;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 2'b11;
        step();
        step();
        checks++;
        if (fm_rst !== 1'b1 || busy !== 1'b0 || gnt !== 2'b00) begin
            failures++;
            $display("FAIL reset_state got fm_rst=%b busy=%b gnt=%b expected 1 0 00",
                     fm_rst, busy, gnt);
        end
        req   = 2'b00;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_matrix();
        int steps, en_cnt;
        logic [1:0] d;
        bit stable;
        req      = 2'b01;
        req_mode = 2'b01;
        wait_done(-1, -1, steps, en_cnt, d, stable);
        req = 2'b00;
        checks++;
        // Done arrives in the 15th cycle counting the request cycle as the
        // first, i.e. 14 edges after the request is applied.
        if (d !== 2'b01 || steps != MAT_LEN + 2 || en_cnt != MAT_LEN) begin
            failures++;
            $display("FAIL single_matrix got done=%b edges=%0d en=%0d expected 01 %0d %0d",
                     d, steps, en_cnt, MAT_LEN + 2, MAT_LEN);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_matrix_idle got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_parallel();
        int steps, en_cnt;
        logic [1:0] d;
        bit stable;
        req      = 2'b10;
        req_mode = 2'b01;
        wait_done(-1, -1, steps, en_cnt, d, stable);
        req = 2'b00;
        checks++;
        if (d !== 2'b10 || steps != PAR_LEN + 2 || en_cnt != PAR_LEN || !stable) begin
            failures++;
            $display("FAIL parallel got done=%b edges=%0d en=%0d stable=%0d expected 10 %0d %0d 1",
                     d, steps, en_cnt, stable, PAR_LEN + 2, PAR_LEN);
        end
        step();
    endtask

    task automatic test_contention();
        logic [1:0] seq [4];
        logic [1:0] expect_d;
        int n = 0;
        int cyc = 0;
        req      = 2'b11;
        req_mode = 2'($urandom_range(0, 3));
        while (n < 4 && cyc < 100) begin
            step();
            cyc++;
            if (done != 2'b00) begin
                seq[n] = done;
                n++;
            end
        end
        req = 2'b00;
        // Requester 1 was served last, so requester 0 goes first.
        expect_d = 2'b01;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= n || seq[i] !== expect_d) begin
                failures++;
                $display("FAIL contention job %0d got done=%b expected %b",
                         i, (i < n) ? seq[i] : 2'b00, expect_d);
            end
            expect_d = ~expect_d;
        end
        step();
        step();
    endtask

    task automatic test_early_release();
        int steps, en_cnt;
        logic [1:0] d;
        bit stable;
        req      = 2'b01;
        req_mode = 2'b01;
        wait_done(3, -1, steps, en_cnt, d, stable);
        req = 2'b00;
        checks++;
        if (d !== 2'b01 || steps != MAT_LEN + 2 || en_cnt != MAT_LEN) begin
            failures++;
            $display("FAIL early_release got done=%b edges=%0d en=%0d expected 01 %0d %0d",
                     d, steps, en_cnt, MAT_LEN + 2, MAT_LEN);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        int steps, en_cnt;
        logic [1:0] d;
        bit stable;
        int guard = 0;
        en_cnt   = 0;
        req      = 2'b10;
        req_mode = 2'b10;
        while (en_cnt < 5 && guard < 20) begin
            step();
            guard++;
            if (fm_en) en_cnt++;
        end
        rst_n = 1'b0;
        step();
        checks++;
        if ({gnt, done, busy, fm_en, fm_mat_mode, res_capture} !== 8'h00 || fm_rst !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_run got gnt=%b done=%b busy=%b en=%b rst=%b expected all 0, rst 1",
                     gnt, done, busy, fm_en, fm_rst);
        end
        rst_n = 1'b1;
        req   = 2'b00;
        step();
        req      = 2'b10;
        req_mode = 2'b00;
        wait_done(-1, -1, steps, en_cnt, d, stable);
        req = 2'b00;
        checks++;
        if (d !== 2'b10 || steps != PAR_LEN + 2 || en_cnt != PAR_LEN) begin
            failures++;
            $display("FAIL after_reset_job got done=%b edges=%0d en=%0d expected 10 %0d %0d",
                     d, steps, en_cnt, PAR_LEN + 2, PAR_LEN);
        end
        step();
    endtask

    task automatic test_mode_sampling();
        int steps, en_cnt;
        logic [1:0] d;
        bit stable;
        req      = 2'b01;
        req_mode = 2'b01;
        wait_done(-1, 2, steps, en_cnt, d, stable);
        req = 2'b00;
        checks++;
        if (d !== 2'b01 || en_cnt != MAT_LEN || !stable) begin
            failures++;
            $display("FAIL mode_sampling got done=%b en=%0d stable=%0d expected 01 %0d 1",
                     d, en_cnt, stable, MAT_LEN);
        end
        step();
    endtask

    // Random request levels, modes and occasional resets; the per-cycle
    // model comparison in step() does the checking.
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) req = 2'($urandom_range(0, 3));
            req_mode = 2'($urandom_range(0, 3));
            rst_n    = ($urandom_range(0, 79) != 0);
            step();
        end
        rst_n = 1'b1;
        req   = 2'b00;
        step();
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = 2'b00;
        req_mode = 2'b00;
        @(negedge clk);
        test_reset();
        test_single_matrix();
        test_parallel();
        test_contention();
        test_early_release();
        test_reset_mid_run();
        test_mode_sampling();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
